// File: rtl/button_mmio_in_pkg.sv
// Shared definitions for the push-button MMIO input peripheral:
// register offsets, STATUS bit positions and the default window base.
package button_mmio_in_pkg;

    // Word offset inside the 16-byte window, taken from adr[3:2].
    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_UP_CNT = 2'd1,
        REG_DN_CNT = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    localparam int ST_UP_PEND = 0;
    localparam int ST_DN_PEND = 1;
    localparam int ST_UP_LVL  = 2;
    localparam int ST_DN_LVL  = 3;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_00F0;

    function automatic logic [3:0] pack_status(input logic up_pend,
                                               input logic dn_pend,
                                               input logic up_lvl,
                                               input logic dn_lvl);
        logic [3:0] s;
        s             = '0;
        s[ST_UP_PEND] = up_pend;
        s[ST_DN_PEND] = dn_pend;
        s[ST_UP_LVL]  = up_lvl;
        s[ST_DN_LVL]  = dn_lvl;
        return s;
    endfunction

endpackage

// File: rtl/button_mmio_in_debounce.sv
// Per-button two-flop synchroniser, stability counter and press (rise) pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            // Any glitch back to the accepted level restarts the stability window.
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_p1;
                cnt   <= '0;
                rise  <= sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_mmio_in.sv
// Read-only MMIO window exposing debounced up/down button status and press counters.
// Optional BTN_IRQ_EN adds a registered irq output driven by the pending flags.
module button_mmio_in
    import button_mmio_in_pkg::*;
#(
    parameter int              WIDTH           = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR      = WIDTH'(DEFAULT_BASE_ADDR),
    parameter int unsigned     DEBOUNCE_CYCLES = 1000000,
    parameter int              CNT_BITS        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up,
    input  logic             down,
    input  logic             memread,
    input  logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] rdata,
    output logic             hit
`ifdef BTN_IRQ_EN
    ,
    output logic             irq
`endif
);

    logic                up_level;
    logic                up_rise;
    logic                dn_level;
    logic                dn_rise;
    logic                up_pending;
    logic                dn_pending;
    logic [CNT_BITS-1:0] up_cnt;
    logic [CNT_BITS-1:0] dn_cnt;
    logic                sel;
    logic                status_clr;
    reg_sel_e            rd_sel;
    logic [WIDTH-1:0]    rd_word;
    logic                adr_lsb_unused;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
        .clk   (clk),
        .reset (reset),
        .btn   (up),
        .level (up_level),
        .rise  (up_rise)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn_db (
        .clk   (clk),
        .reset (reset),
        .btn   (down),
        .level (dn_level),
        .rise  (dn_rise)
    );

    assign adr_lsb_unused = ^adr[1:0];
    assign sel            = memread && (adr[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
    assign rd_sel         = reg_sel_e'(adr[3:2]);
    assign status_clr     = sel && (rd_sel == REG_STATUS);

    always_comb begin
        rd_word = '0;
        case (rd_sel)
            REG_STATUS: rd_word[3:0]          = pack_status(up_pending, dn_pending,
                                                            up_level, dn_level);
            REG_UP_CNT: rd_word[CNT_BITS-1:0] = up_cnt;
            REG_DN_CNT: rd_word[CNT_BITS-1:0] = dn_cnt;
            default:    rd_word               = '0;
        endcase
    end

    // A press landing on the clearing read keeps its flag: set beats clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            up_pending <= 1'b0;
            dn_pending <= 1'b0;
            up_cnt     <= '0;
            dn_cnt     <= '0;
        end else begin
            if (up_rise) begin
                up_pending <= 1'b1;
                up_cnt     <= up_cnt + 1'b1;
            end else if (status_clr) begin
                up_pending <= 1'b0;
            end
            if (dn_rise) begin
                dn_pending <= 1'b1;
                dn_cnt     <= dn_cnt + 1'b1;
            end else if (status_clr) begin
                dn_pending <= 1'b0;
            end
        end
    end

    // read response stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
            hit   <= 1'b0;
        end else begin
            rdata <= sel ? rd_word : '0;
            hit   <= sel;
        end
    end

`ifdef BTN_IRQ_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= up_pending | dn_pending;
        end
    end
`endif

endmodule

// File: tb/tb_button_mmio_in.sv
// Directed bench for button_mmio_in with DEBOUNCE_CYCLES=4 and base 0xF0.
module tb_button_mmio_in;

    localparam logic [31:0] BASE = 32'h0000_00F0;

    logic        clk = 1'b0;
    logic        reset;
    logic        up;
    logic        down;
    logic        memread;
    logic [31:0] adr;
    logic [31:0] rdata;
    logic        hit;
`ifdef BTN_IRQ_EN
    logic        irq;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    button_mmio_in #(
        .WIDTH(32),
        .BASE_ADDR(BASE),
        .DEBOUNCE_CYCLES(4),
        .CNT_BITS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .up(up),
        .down(down),
        .memread(memread),
        .adr(adr),
        .rdata(rdata),
        .hit(hit)
`ifdef BTN_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    // Called at a negedge; returns what the DUT registered on the next posedge.
    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        memread = 1'b1;
        adr     = a;
        @(negedge clk);
        d       = rdata;
        h       = hit;
        memread = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        h;
        reset = 1'b0; up = 1'b1; memread = 1'b1; adr = BASE;
        repeat (2) @(negedge clk);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b exp=%b", hit, 1'b0); end
        memread = 1'b0;
        reset   = 1'b1;
        repeat (5) @(negedge clk);
        do_read(BASE, d, h);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status_e6 got=%h exp=%h", d, 32'h0); end
        do_read(BASE, d, h);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL reset_status_e7 got=%h exp=%h", d, 32'h4); end
        do_read(BASE, d, h);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL reset_status_e8 got=%h exp=%h", d, 32'h5); end
        do_read(BASE + 32'd4, d, h);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_up_cnt got=%h exp=%h", d, 32'h1); end
        up = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_clean_press();
        logic [31:0] d;
        logic        h;
        up = 1'b1;
        repeat (10) @(negedge clk);
        do_read(BASE, d, h);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL clean_status got=%h exp=%h", d, 32'h5); end
        checks++; if (h !== 1'b1) begin errors++; $display("FAIL clean_hit got=%b exp=%b", h, 1'b1); end
        do_read(BASE, d, h);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL clean_status2 got=%h exp=%h", d, 32'h4); end
        @(negedge clk);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL clean_hit_idle got=%b exp=%b", hit, 1'b0); end
        do_read(BASE + 32'd4, d, h);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL clean_up_cnt got=%h exp=%h", d, 32'h2); end
        up = 1'b0;
        repeat (10) @(negedge clk);
        do_read(BASE, d, h);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clean_release got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_bounce();
        logic [31:0] d;
        logic        h;
        for (int i = 0; i < 5; i++) begin
            down = 1'b1; repeat (2) @(negedge clk);
            down = 1'b0; repeat (2) @(negedge clk);
        end
        do_read(BASE + 32'd8, d, h);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL bounce_cnt_toggling got=%h exp=%h", d, 32'h0); end
        do_read(BASE, d, h);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL bounce_status_toggling got=%h exp=%h", d, 32'h0); end
        down = 1'b1;
        repeat (10) @(negedge clk);
        do_read(BASE + 32'd8, d, h);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL bounce_cnt_held got=%h exp=%h", d, 32'h1); end
        do_read(BASE, d, h);
        checks++; if (d !== 32'hA) begin errors++; $display("FAIL bounce_status got=%h exp=%h", d, 32'hA); end
        do_read(BASE, d, h);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL bounce_status2 got=%h exp=%h", d, 32'h8); end
        down = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic        h;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_read(BASE + 32'd4, d, h);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_cnt_reset got=%h exp=%h", d, 32'h0); end
        for (int i = 0; i < 255; i++) begin
            up = 1'b1; repeat (8) @(negedge clk);
            up = 1'b0; repeat (8) @(negedge clk);
        end
        do_read(BASE + 32'd4, d, h);
        checks++; if (d !== 32'hFF) begin errors++; $display("FAIL wrap_cnt_255 got=%h exp=%h", d, 32'hFF); end
        up = 1'b1; repeat (8) @(negedge clk);
        up = 1'b0; repeat (8) @(negedge clk);
        do_read(BASE + 32'd4, d, h);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_cnt_256 got=%h exp=%h", d, 32'h0); end
        do_read(BASE, d, h);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL wrap_status got=%h exp=%h", d, 32'h1); end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        logic        h;
        do_read(BASE, d, h);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL coll_pre got=%h exp=%h", d, 32'h0); end
        down = 1'b1;
        repeat (6) @(negedge clk);
        do_read(BASE, d, h);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL coll_same_cycle got=%h exp=%h", d, 32'h8); end
        do_read(BASE, d, h);
        checks++; if (d !== 32'hA) begin errors++; $display("FAIL coll_next got=%h exp=%h", d, 32'hA); end
        do_read(BASE, d, h);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL coll_cleared got=%h exp=%h", d, 32'h8); end
        down = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_decode();
        logic [31:0] d;
        logic        h;
        do_read(BASE + 32'd12, d, h);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL dec_rsvd_rdata got=%h exp=%h", d, 32'h0); end
        checks++; if (h !== 1'b1) begin errors++; $display("FAIL dec_rsvd_hit got=%b exp=%b", h, 1'b1); end
        do_read(BASE + 32'd16, d, h);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL dec_above_hit got=%b exp=%b", h, 1'b0); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL dec_above_rdata got=%h exp=%h", d, 32'h0); end
        do_read(BASE + 32'd9, d, h);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL dec_lsb_ignored got=%h exp=%h", d, 32'h1); end
        do_read(BASE - 32'd16, d, h);
        checks++; if (h !== 1'b0) begin errors++; $display("FAIL dec_below_hit got=%b exp=%b", h, 1'b0); end
        memread = 1'b0;
        adr     = BASE;
        @(negedge clk);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL dec_no_memread_hit got=%b exp=%b", hit, 1'b0); end
    endtask

`ifdef BTN_IRQ_EN
    task automatic test_irq();
        logic [31:0] d;
        logic        h;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b exp=%b", irq, 1'b0); end
        up = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=%b", irq, 1'b1); end
        do_read(BASE, d, h);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_lag got=%b exp=%b", irq, 1'b1); end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop got=%b exp=%b", irq, 1'b0); end
        up = 1'b0;
        repeat (10) @(negedge clk);
    endtask
`endif

    initial begin
        reset   = 1'b0;
        up      = 1'b0;
        down    = 1'b0;
        memread = 1'b0;
        adr     = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrap();
        test_collision();
        test_decode();
`ifdef BTN_IRQ_EN
        test_irq();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
